act_lut_stage: RTL
==================

ACT_LUT_STAGE -- requirements
Module: act_lut_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of activation output and LUT entry.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the LUT index width (16 entries).
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the width of each saturation counter.
REQ-004 Ports SHALL be, clock and reset first:
  i_clk  in  1  single clock, rising edge
  i_rst_n  in  1  asynchronous active-low reset
  i_cfg_we  in  1  config write strobe
  i_cfg_addr  in  5  0..15 LUT entry, 16 max clamp, 17 min clamp, others ignored
  i_cfg_data  in  DATA_WIDTH  config write data
  i_in_valid  in  1  upstream address/flags valid
  o_in_ready  out  1  stage accepts input this cycle
  i_lut_addr  in  ADDR_WIDTH  LUT index from address generator
  i_max_value_en  in  1  input saturated high
  i_min_value_en  in  1  input saturated low
  o_out_valid  out  1  o_act_dat valid
  i_out_ready  in  1  downstream accepts
  o_act_dat  out  DATA_WIDTH  signed activation result
  i_cnt_clr  in  1  synchronous clear of both counters
  o_sat_max_cnt  out  CNT_WIDTH  count of accepted max-saturated inputs
  o_sat_min_cnt  out  CNT_WIDTH  count of accepted min-saturated inputs

Function
REQ-005 The block SHALL hold a 16 x DATA_WIDTH LUT register array plus max clamp and min clamp registers, each written on i_cfg_we at the addressed location.
REQ-006 Accept SHALL occur when i_in_valid && o_in_ready.
REQ-007 Pipeline advance enable SHALL be adv = !o_out_valid || i_out_ready; o_in_ready SHALL equal adv (combinational).
REQ-008 Stage 1 SHALL, on adv, register index, max flag, min flag and valid (= accept).
REQ-009 Stage 2 SHALL, on adv, register result and valid from stage 1; o_out_valid and o_act_dat SHALL be stage 2 registers.
REQ-010 Result selection: max flag -> max clamp; else min flag -> min clamp; else LUT[index]; max SHALL take priority when both set.
REQ-011 Latency SHALL be 2 cycles accept-to-o_out_valid; sustained throughput 1 per cycle while i_out_ready=1.
REQ-012 While o_out_valid && !i_out_ready, both stages and o_act_dat SHALL hold unchanged and o_in_ready SHALL be 0.
REQ-013 LUT/clamp selection SHALL occur at stage-1-to-stage-2 transfer; a config write in the same cycle SHALL NOT affect that transfer (old value used), and SHALL apply from the next cycle.
REQ-014 Config writes SHALL be accepted regardless of stall state; out-of-range i_cfg_addr (18..31) SHALL write nothing.
REQ-015 Counters SHALL increment on accept with the corresponding flag (max counter only when both set), saturating at all-ones.
REQ-016 i_cnt_clr SHALL zero both counters next cycle and win over a simultaneous increment.

Reset
REQ-017 On i_rst_n low, asynchronously: stage valids, o_out_valid = 0; o_act_dat = 0; counters = 0; LUT entries = 0; max clamp = 8'h08; min clamp = 8'hF8.
REQ-018 Reset mid-stream SHALL discard all in-flight data; o_in_ready SHALL be 1 in the first cycle after release.

Structure
REQ-019 Shared package SHALL hold DATA_WIDTH, ADDR_WIDTH, config address constants (CFG_MAX=16, CFG_MIN=17) and clamp reset values 8'h08/8'hF8, shared with the address generator.
REQ-020 One sub-module, act_lut_regfile (LUT + clamp registers, write port, combinational read), SHALL be instantiated; the pipeline and counters SHALL stay in act_lut_stage.

Verification
REQ-021 Write LUT[i]=i*3 for i=0..15, stream addr 0..15 with i_out_ready=1 -> outputs 0,3,...,45 back-to-back, first valid 2 cycles after first accept.
REQ-022 Stream addr 5 with max flag, then addr 5 with min flag, then both flags -> outputs 8'h08, 8'hF8, 8'h08; max count 2, min count 1.
REQ-023 Hold i_out_ready=0 for 5 cycles with 3 inputs offered -> o_in_ready=0 after pipeline fills, o_act_dat stable; release -> all 3 delivered in order, none lost or duplicated.
REQ-024 Write LUT[4]=8'h55 in the same cycle entry 4 moves to stage 2 (old 8'h11) -> output 8'h11; next access to index 4 -> 8'h55.
REQ-025 Drive 2^CNT_WIDTH+3 max-flag accepts -> o_sat_max_cnt stays at all-ones; assert i_cnt_clr with a concurrent max accept -> counter reads 0.
REQ-026 Assert i_rst_n low with 2 items in flight -> o_out_valid=0 immediately, clamps back to 8'h08/8'hF8, LUT entries 0.

Source files
------------

// File: rtl/act_lut_stage_pkg.sv
// rtl/act_lut_stage_pkg.sv - shared widths, config map and clamp reset values for the activation LUT path
package act_lut_stage_pkg;

   localparam int DATA_WIDTH     = 8;
   localparam int ADDR_WIDTH     = 4;
   localparam int CFG_ADDR_WIDTH = 5;

   localparam logic [CFG_ADDR_WIDTH-1:0] CFG_MAX = 5'd16;
   localparam logic [CFG_ADDR_WIDTH-1:0] CFG_MIN = 5'd17;

   localparam logic [7:0] MAX_CLAMP_RST = 8'h08;
   localparam logic [7:0] MIN_CLAMP_RST = 8'hF8;

   typedef enum logic [1:0] {
      SEL_LUT = 2'd0,
      SEL_MAX = 2'd1,
      SEL_MIN = 2'd2
   } sel_e;

   // High saturation dominates when the address generator flags both ends.
   function automatic sel_e pick_sel(input logic max_en, input logic min_en);
      if (max_en)      return SEL_MAX;
      else if (min_en) return SEL_MIN;
      else             return SEL_LUT;
   endfunction

endpackage

// File: rtl/act_lut_stage_if.sv
// rtl/act_lut_stage_if.sv - input address/flag handshake and activation output handshake
interface act_lut_stage_if #(
   parameter int DATA_WIDTH = act_lut_stage_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = act_lut_stage_pkg::ADDR_WIDTH
);
   logic                  i_in_valid;
   logic                  o_in_ready;
   logic [ADDR_WIDTH-1:0] i_lut_addr;
   logic                  i_max_value_en;
   logic                  i_min_value_en;
   logic                  o_out_valid;
   logic                  i_out_ready;
   logic [DATA_WIDTH-1:0] o_act_dat;

   modport slave (
      input  i_in_valid, i_lut_addr, i_max_value_en, i_min_value_en, i_out_ready,
      output o_in_ready, o_out_valid, o_act_dat
   );

   modport master (
      output i_in_valid, i_lut_addr, i_max_value_en, i_min_value_en, i_out_ready,
      input  o_in_ready, o_out_valid, o_act_dat
   );
endinterface

// File: rtl/act_lut_regfile.sv
// rtl/act_lut_regfile.sv - LUT and clamp registers with one write port and combinational read
module act_lut_regfile #(
   parameter int DATA_WIDTH = act_lut_stage_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = act_lut_stage_pkg::ADDR_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_we,
   input  logic [4:0]            i_addr,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [ADDR_WIDTH-1:0] i_rd_idx,
   output logic [DATA_WIDTH-1:0] o_rd_dat,
   output logic [DATA_WIDTH-1:0] o_max_clamp,
   output logic [DATA_WIDTH-1:0] o_min_clamp
);
   import act_lut_stage_pkg::*;

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_lut [DEPTH];
   logic [DATA_WIDTH-1:0] r_max_clamp;
   logic [DATA_WIDTH-1:0] r_min_clamp;

   // Addresses past the clamp slots fall through every branch and write nothing.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_lut[i] <= '0;
         r_max_clamp <= DATA_WIDTH'(MAX_CLAMP_RST);
         r_min_clamp <= DATA_WIDTH'(MIN_CLAMP_RST);
      end else if (i_we) begin
         if (i_addr == CFG_MAX)
            r_max_clamp <= i_data;
         else if (i_addr == CFG_MIN)
            r_min_clamp <= i_data;
         else if (i_addr < 5'(DEPTH))
            r_lut[i_addr[ADDR_WIDTH-1:0]] <= i_data;
      end
   end

   assign o_rd_dat    = r_lut[i_rd_idx];
   assign o_max_clamp = r_max_clamp;
   assign o_min_clamp = r_min_clamp;

endmodule

// File: rtl/act_lut_stage.sv
// rtl/act_lut_stage.sv - two-stage activation lookup with clamp override and saturation counters
module act_lut_stage #(
   parameter int DATA_WIDTH = act_lut_stage_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = act_lut_stage_pkg::ADDR_WIDTH,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_cfg_we,
   input  logic [4:0]            i_cfg_addr,
   input  logic [DATA_WIDTH-1:0] i_cfg_data,
   act_lut_stage_if.slave        bus,
   input  logic                  i_cnt_clr,
   output logic [CNT_WIDTH-1:0]  o_sat_max_cnt,
   output logic [CNT_WIDTH-1:0]  o_sat_min_cnt
);
   import act_lut_stage_pkg::*;

   logic                  w_adv;
   logic                  w_accept;
   logic [DATA_WIDTH-1:0] w_lut_dat;
   logic [DATA_WIDTH-1:0] w_max_clamp;
   logic [DATA_WIDTH-1:0] w_min_clamp;
   logic [DATA_WIDTH-1:0] w_result;

   logic                  r_s1_valid;
   logic [ADDR_WIDTH-1:0] r_s1_idx;
   logic                  r_s1_max;
   logic                  r_s1_min;
   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_act_dat;
   logic [CNT_WIDTH-1:0]  r_max_cnt;
   logic [CNT_WIDTH-1:0]  r_min_cnt;

   assign w_adv    = !r_out_valid || bus.i_out_ready;
   assign w_accept = bus.i_in_valid && w_adv;

   // Read happens from stage 1, so a same-cycle config write lands after this transfer.
   act_lut_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_regfile (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_we        (i_cfg_we),
      .i_addr      (i_cfg_addr),
      .i_data      (i_cfg_data),
      .i_rd_idx    (r_s1_idx),
      .o_rd_dat    (w_lut_dat),
      .o_max_clamp (w_max_clamp),
      .o_min_clamp (w_min_clamp)
   );

   always_comb begin
      w_result = w_lut_dat;
      case (pick_sel(r_s1_max, r_s1_min))
         SEL_MAX: w_result = w_max_clamp;
         SEL_MIN: w_result = w_min_clamp;
         default: w_result = w_lut_dat;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_idx    <= '0;
         r_s1_max    <= 1'b0;
         r_s1_min    <= 1'b0;
         r_out_valid <= 1'b0;
         r_act_dat   <= '0;
      end else if (w_adv) begin
         r_s1_valid  <= w_accept;
         r_s1_idx    <= bus.i_lut_addr;
         r_s1_max    <= bus.i_max_value_en;
         r_s1_min    <= bus.i_min_value_en;
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) r_act_dat <= w_result;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_max_cnt <= '0;
         r_min_cnt <= '0;
      end else if (i_cnt_clr) begin
         r_max_cnt <= '0;
         r_min_cnt <= '0;
      end else if (w_accept) begin
         if (bus.i_max_value_en) begin
            if (r_max_cnt != '1) r_max_cnt <= r_max_cnt + CNT_WIDTH'(1);
         end else if (bus.i_min_value_en) begin
            if (r_min_cnt != '1) r_min_cnt <= r_min_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign bus.o_in_ready  = w_adv;
   assign bus.o_out_valid = r_out_valid;
   assign bus.o_act_dat   = r_act_dat;
   assign o_sat_max_cnt   = r_max_cnt;
   assign o_sat_min_cnt   = r_min_cnt;

endmodule
